axi4_chan_buf: RTL and testbench



---
 rtl/axi_pkg.sv | 70 +++++++
 rtl/axi4_buf_ptr.sv | 57 +++++
 rtl/axi4_chan_buf.sv | 108 ++++++++++
 tb/tb_axi4_chan_buf.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI4 channel payload widths, packed channel structs and buffer sizing helpers
package axi_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;

  // AW/AR carry id, addr, len, size(3), burst(2).
  function automatic int unsigned ax_payload_w(input int unsigned id_w, input int unsigned addr_w,
                                               input int unsigned len_w);
    return id_w + addr_w + len_w + 3 + 2;
  endfunction

  function automatic int unsigned w_payload_w(input int unsigned data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  function automatic int unsigned b_payload_w(input int unsigned id_w);
    return id_w + 2;
  endfunction

  function automatic int unsigned r_payload_w(input int unsigned id_w, input int unsigned data_w);
    return id_w + data_w + 2 + 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned AW_PAYLOAD_W = ax_payload_w(ID_W, ADDR_W, LEN_W);
  localparam int unsigned AR_PAYLOAD_W = ax_payload_w(ID_W, ADDR_W, LEN_W);
  localparam int unsigned W_PAYLOAD_W  = w_payload_w(DATA_W);
  localparam int unsigned B_PAYLOAD_W  = b_payload_w(ID_W);
  localparam int unsigned R_PAYLOAD_W  = r_payload_w(ID_W, DATA_W);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } axi_ax_t;

  typedef axi_ax_t axi_aw_t;
  typedef axi_ax_t axi_ar_t;

  // last is the final member so it lands on bit 0 of the packed vector.
  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
  } axi_w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } axi_b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;

  localparam int unsigned W_LAST_BIT = 0;
  localparam int unsigned R_LAST_BIT = 0;

endpackage

// File: rtl/axi4_buf_ptr.sv
// rtl/axi4_buf_ptr.sv - wrap-bit read/write pointers, full/empty and occupancy count
module axi4_buf_ptr
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       push,
  input  logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count   = count_q;

endmodule

// File: rtl/axi4_chan_buf.sv
// rtl/axi4_chan_buf.sv - registered valid/ready buffer for one AXI4 channel
// Define AXI4_BUF_STORE_FWD_EN to hold beats until a whole burst is resident.
module axi4_chan_buf
  import axi_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AF_LEVEL  = 3,
  parameter int unsigned LAST_BIT  = 0
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [PAYLOAD_W-1:0]       s_payload,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PAYLOAD_W-1:0]       m_payload,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  if (LAST_BIT >= PAYLOAD_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_cfg
    $error("axi4_chan_buf: invalid parameter set");
  end

  logic                 push, pop, full, empty;
  logic [AW-1:0]        wr_addr, rd_addr;
  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [PAYLOAD_W-1:0] mem_d [DEPTH];
  logic                 in_reset_q, in_reset_d;

  axi4_buf_ptr #(.DEPTH(DEPTH)) u_ptr (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .push    (push),
    .pop     (pop),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Holds s_ready low from reset assertion until the first edge after release.
  assign in_reset_d = 1'b0;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) in_reset_q <= 1'b1;
    else        in_reset_q <= in_reset_d;
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_addr] = s_payload;
  end

  always_ff @(posedge ACLK) begin
    mem_q <= mem_d;
  end

  assign s_ready     = !full && !in_reset_q;
  assign push        = s_valid && s_ready;
  assign pop         = m_valid && m_ready;
  assign m_payload   = m_valid ? mem_q[rd_addr] : '0;
  assign almost_full = (count >= CW'(AF_LEVEL));

`ifdef AXI4_BUF_STORE_FWD_EN
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          fwd_lock_q, fwd_lock_d;
  logic          push_last, pop_last;

  assign push_last = push && s_payload[LAST_BIT];
  assign pop_last  = pop && m_payload[LAST_BIT];

  // A full buffer with no last beat can never complete a burst, so cut through.
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    fwd_lock_d = fwd_lock_q;
    case ({push_last, pop_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    if (full && pkt_cnt_q == '0) fwd_lock_d = 1'b1;
    if (pop_last)                fwd_lock_d = 1'b0;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pkt_cnt_q  <= '0;
      fwd_lock_q <= 1'b0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      fwd_lock_q <= fwd_lock_d;
    end
  end

  assign m_valid = !empty && (pkt_cnt_q != '0 || full || fwd_lock_q);
`else
  assign m_valid = !empty;
`endif

endmodule

// File: tb/tb_axi4_chan_buf.sv
// tb/tb_axi4_chan_buf.sv - directed and scoreboard checks for axi4_chan_buf
module tb_axi4_chan_buf;

  logic        ACLK;
  logic        ARESET;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_payload;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_payload;
  logic [2:0]  count;
  logic        almost_full;

  int checks;
  int errors;

  axi4_chan_buf #(
    .PAYLOAD_W (32),
    .DEPTH     (4),
    .AF_LEVEL  (3),
    .LAST_BIT  (0)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_payload   (s_payload),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_payload   (m_payload),
    .count       (count),
    .almost_full (almost_full)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_payload = '0;
    repeat (2) step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %0b want 0", s_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %0b want 0", almost_full); end
    checks++; if (m_payload !== 32'h0) begin errors++; $display("FAIL reset_m_payload got %0h want 0", m_payload); end
    ARESET = 1'b0;
    #2;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL release_s_ready_before_edge got %0b want 0", s_ready); end
    step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready_after_edge got %0b want 1", s_ready); end
  endtask

  task automatic test_fill_drain();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_payload = 32'hA0 + i;
      step();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 3)) begin errors++; $display("FAIL fill_almost_full got %0b want %0b", almost_full, (i + 1 >= 3)); end
      checks++; if (m_payload !== 32'hA0) begin errors++; $display("FAIL fill_head got %0h want a0", m_payload); end
    end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready_full got %0b want 0", s_ready); end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_valid !== 1'b1 || m_payload !== 32'hA0 + i) begin errors++; $display("FAIL drain_data got %0b/%0h want 1/%0h", m_valid, m_payload, 32'hA0 + i); end
      step();
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
    checks++; if (m_valid !== 1'b0 || m_payload !== 32'h0) begin errors++; $display("FAIL drain_empty got %0b/%0h want 0/0", m_valid, m_payload); end
    m_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      s_payload = i;
      step();
      checks++; if (m_valid !== 1'b1 || m_payload !== 32'(i)) begin errors++; $display("FAIL stream_data got %0b/%0d want 1/%0d", m_valid, m_payload, i); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count got %0d want 1", count); end
    end
    s_valid = 1'b0;
    step();
    checks++; if (count !== 3'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %0d/%0b want 0/0", count, m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_full_pop_push();
    s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_payload = 32'hB0 + i;
      step();
    end
    s_payload = 32'hB4; m_ready = 1'b1;
    checks++; if (s_ready !== 1'b0 || count !== 3'd4) begin errors++; $display("FAIL full_pop_cycle got %0b/%0d want 0/4", s_ready, count); end
    step();
    m_ready = 1'b0;
    checks++; if (count !== 3'd3 || s_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop got %0d/%0b want 3/1", count, s_ready); end
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_after_push got %0d want 4", count); end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (m_payload !== 32'hB0 + i) begin errors++; $display("FAIL full_drain got %0h want %0h", m_payload, 32'hB0 + i); end
      step();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_payload = 32'hC0 + i;
      step();
    end
    s_valid = 1'b0;
    #2;
    ARESET = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL midrst_handshake got %0b/%0b want 0/0", m_valid, s_ready); end
    checks++; if (count !== 3'd0 || almost_full !== 1'b0) begin errors++; $display("FAIL midrst_count got %0d/%0b want 0/0", count, almost_full); end
    step();
    ARESET = 1'b0;
    step();
    s_valid = 1'b1; s_payload = 32'hD0;
    step();
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_payload !== 32'hD0 || count !== 3'd1) begin errors++; $display("FAIL midrst_first got %0b/%0h/%0d want 1/d0/1", m_valid, m_payload, count); end
    m_ready = 1'b1;
    step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale got %0b want 0", m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] sb[$];
    int sent, rcvd, cyc;
    logic        prev_stall;
    logic [31:0] prev_data;
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (rcvd < 1000 && cyc < 10000) begin
      s_valid   = (sent < 1000) && ($urandom_range(1) == 1);
      s_payload = $urandom;
      m_ready   = ($urandom_range(1) == 1);
      #1;
      if (prev_stall) begin
        checks++; if (m_valid !== 1'b1 || m_payload !== prev_data) begin errors++; $display("FAIL rand_stable got %0b/%0h want 1/%0h", m_valid, m_payload, prev_data); end
      end
      checks++; if (count !== 3'(sb.size())) begin errors++; $display("FAIL rand_count got %0d want %0d", count, sb.size()); end
      if (m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rand_dup got %0h want none", m_payload); end
        else begin
          if (m_payload !== sb[0]) begin errors++; $display("FAIL rand_order got %0h want %0h", m_payload, sb[0]); end
          void'(sb.pop_front());
        end
        rcvd++;
      end
      if (s_valid && s_ready) begin sb.push_back(s_payload); sent++; end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_payload;
      step();
      cyc++;
    end
    checks++; if (rcvd != 1000) begin errors++; $display("FAIL rand_timeout got %0d want 1000", rcvd); end
    s_valid = 1'b0; m_ready = 1'b0;
  endtask

`ifdef AXI4_BUF_STORE_FWD_EN
  task automatic test_store_fwd();
    logic [31:0] burst [6];
    int in_idx, out_idx, cyc;
    logic seen_full;
    m_ready = 1'b0; s_valid = 1'b1;
    s_payload = 32'h10; step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL sf_hold1 got %0b want 0", m_valid); end
    s_payload = 32'h12; step();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL sf_hold2 got %0b want 0", m_valid); end
    s_payload = 32'h13; step();
    s_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_payload !== 32'h10) begin errors++; $display("FAIL sf_release got %0b/%0h want 1/10", m_valid, m_payload); end
    m_ready = 1'b1;
    step(); step(); step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sf_drain got %0d want 0", count); end

    burst[0] = 32'h20; burst[1] = 32'h22; burst[2] = 32'h24;
    burst[3] = 32'h26; burst[4] = 32'h28; burst[5] = 32'h2B;
    in_idx = 0; out_idx = 0; cyc = 0; seen_full = 1'b0;
    while (out_idx < 6 && cyc < 40) begin
      s_valid = (in_idx < 6);
      s_payload = (in_idx < 6) ? burst[in_idx] : 32'h0;
      #1;
      if (count == 3'd4) seen_full = 1'b1;
      if (m_valid && m_ready) begin
        checks++; if (!seen_full || m_payload !== burst[out_idx]) begin errors++; $display("FAIL sf_long got %0b/%0h want 1/%0h", seen_full, m_payload, burst[out_idx]); end
        out_idx++;
      end
      if (s_valid && s_ready) in_idx++;
      step();
      cyc++;
    end
    s_valid = 1'b0;
    checks++; if (out_idx != 6 || m_valid !== 1'b0) begin errors++; $display("FAIL sf_long_done got %0d/%0b want 6/0", out_idx, m_valid); end
    s_valid = 1'b1; s_payload = 32'h30;
    step();
    s_valid = 1'b0;
    step();
    checks++; if (m_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL sf_lock_clear got %0b/%0d want 0/1", m_valid, count); end
  endtask
`endif

  initial begin
    checks = 0; errors = 0;
    test_reset();
`ifdef AXI4_BUF_STORE_FWD_EN
    test_store_fwd();
`else
    test_fill_drain();
    test_back_to_back();
    test_full_pop_push();
    test_reset_midstream();
    test_random();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
